// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 8-digit common-anode 7-segment scan controller with blanking gaps.
// Optional macro SEG_PWM_EN adds a bright[2:0] input for segment duty control.
module seg_scan_ctrl #(
  parameter int NDIG      = 8,
  parameter int SCAN_DIV  = 1024,
  parameter int BLANK_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [4:0] wr_data,
  input  logic [7:0] en_mask,
`ifdef SEG_PWM_EN
  input  logic [2:0] bright,
`endif
  output logic [7:0] LED7S,
  output logic [7:0] dig,
  output logic       frame_tick
);

  localparam int CW = $clog2(SCAN_DIV > BLANK_CYC ? SCAN_DIV : BLANK_CYC) + 1;
  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  logic [4:0]    regs_q [8];
  logic [4:0]    regs_d [8];
  logic [0:0]    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start_q, start_d;
  logic [7:0]    led_q, led_d;
  logic [7:0]    dig_q, dig_d;
  logic          tick;

  logic [2:0] nxt;
  logic       found;
  logic [3:0] base, cand;
  logic [4:0] cur;
  logic       seg_on;

  function automatic logic [7:0] hex2seg(input logic [3:0] v);
    case (v)
      4'h0: hex2seg = 8'hC0;  4'h1: hex2seg = 8'hF9;
      4'h2: hex2seg = 8'hA4;  4'h3: hex2seg = 8'hB0;
      4'h4: hex2seg = 8'h99;  4'h5: hex2seg = 8'h92;
      4'h6: hex2seg = 8'h82;  4'h7: hex2seg = 8'hF8;
      4'h8: hex2seg = 8'h80;  4'h9: hex2seg = 8'h90;
      4'hA: hex2seg = 8'h88;  4'hB: hex2seg = 8'h83;
      4'hC: hex2seg = 8'hC6;  4'hD: hex2seg = 8'hA1;
      4'hE: hex2seg = 8'h86;  default: hex2seg = 8'h8E;
    endcase
  endfunction

  // Next enabled digit, searching cyclically from idx+1 with idx itself last.
  // Right after reset the search starts at idx so the first frame begins at digit 0.
  always_comb begin
    nxt   = idx_q;
    found = 1'b0;
    cand  = '0;
    base  = start_q ? {1'b0, idx_q} : {1'b0, idx_q} + 4'd1;
    if (base >= 4'(NDIG)) base = base - 4'(NDIG);
    for (int k = 0; k < NDIG; k++) begin
      cand = base + 4'(k);
      if (cand >= 4'(NDIG)) cand = cand - 4'(NDIG);
      if (!found && en_mask[cand[2:0]]) begin
        found = 1'b1;
        nxt   = cand[2:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    start_d = start_q;
    tick    = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d = '0;
          if (found) begin
            state_d = ST_SHOW;
            idx_d   = nxt;
            start_d = 1'b0;
            tick    = !start_q && (nxt <= idx_q);
          end
        end
      end
      ST_SHOW: begin
        if (!en_mask[idx_q] || cnt_q == SHOW_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    regs_d = regs_q;
    if (wr_en && ({1'b0, wr_addr} < 4'(NDIG))) regs_d[wr_addr] = wr_data;
  end

  // Outputs are registered from the next-state values so dig/LED7S track state_q exactly;
  // the register file is read pre-write, giving write-first on the following cycle.
  always_comb begin
    cur = regs_q[idx_d];
`ifdef SEG_PWM_EN
    seg_on = (cnt_d[2:0] <= bright);
`else
    seg_on = 1'b1;
`endif
    dig_d = 8'hFF;
    led_d = 8'hFF;
    if (state_d == ST_SHOW) begin
      dig_d = ~(8'd1 << idx_d);
      if (seg_on) begin
        led_d = hex2seg(cur[3:0]);
        if (cur[4]) led_d[7] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= 5'h00;
      state_q <= ST_BLANK;
      idx_q   <= 3'd0;
      cnt_q   <= '0;
      start_q <= 1'b1;
      led_q   <= 8'hFF;
      dig_q   <= 8'hFF;
    end else begin
      regs_q  <= regs_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      start_q <= start_d;
      led_q   <= led_d;
      dig_q   <= dig_d;
    end
  end

  assign LED7S      = led_q;
  assign dig        = dig_q;
  assign frame_tick = tick && !rst;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NDIG=8, SCAN_DIV=8, BLANK_CYC=2.
module tb_seg_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [4:0] wr_data = '0;
  logic [7:0] en_mask = 8'hFF;
  logic [2:0] bright = 3'd7;
  logic [7:0] LED7S, dig;
  logic       frame_tick;
  int         n_chk = 0;
  int         n_fail = 0;

  seg_scan_ctrl #(.NDIG(8), .SCAN_DIV(8), .BLANK_CYC(2)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .en_mask(en_mask),
`ifdef SEG_PWM_EN
    .bright(bright),
`endif
    .LED7S(LED7S), .dig(dig), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         skip;
    logic       rst;
    logic       we;
    logic [2:0] a;
    logic [4:0] d;
    logic [7:0] edig;
    logic [7:0] eled;
    logic       etick;
  } vec_t;

  vec_t vt[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int t, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d: got %h expected %h", name, t, act, exp);
    end
  endtask

  task automatic check_all(input string name, input int t, input logic [7:0] ed,
                           input logic [7:0] el, input logic et);
    check({name, "_dig"}, t, dig, ed);
    check({name, "_led"}, t, LED7S, el);
    check({name, "_tick"}, t, {7'd0, frame_tick}, {7'd0, et});
  endtask

  // Reset, then follow the enabled digits in order: 2 blank cycles lead in, then
  // 8 SHOW + 2 BLANK per digit; frame_tick on the last BLANK cycle before each wrap.
  task automatic run_scan(input logic [7:0] mask, input int k, input logic [7:0][2:0] lst,
                          input int ncyc);
    logic [7:0] one8, ed, el;
    logic       et;
    int         p, slot;
    one8 = 8'd1;
    en_mask = mask;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all("scan_reset", 0, 8'hFF, 8'hFF, 1'b0);
    for (int t = 1; t <= ncyc; t++) begin
      tick();
      ed = 8'hFF; el = 8'hFF; et = 1'b0;
      if (t >= 2) begin
        p    = (t - 2) % 10;
        slot = (t - 2) / 10;
        if (p < 8) begin
          ed = ~(one8 << lst[slot % k]);
          el = 8'hC0;
        end
        et = ((t - 2) % (10 * k)) == (10 * k - 1);
      end
      check_all("scan", t, ed, el, et);
    end
  endtask

  initial begin
    // Write port, write-first timing, and reset-over-write, all with every digit enabled.
    vt[0]  = '{0,  1'b1, 1'b0, 3'd0, 5'h00, 8'hFF, 8'hFF, 1'b0};
    vt[1]  = '{0,  1'b0, 1'b1, 3'd3, 5'h1A, 8'hFF, 8'hFF, 1'b0};
    vt[2]  = '{0,  1'b0, 1'b0, 3'd0, 5'h00, 8'hFE, 8'hC0, 1'b0};
    vt[3]  = '{29, 1'b0, 1'b0, 3'd0, 5'h00, 8'hF7, 8'h08, 1'b0};
    vt[4]  = '{7,  1'b0, 1'b0, 3'd0, 5'h00, 8'hFF, 8'hFF, 1'b0};
    vt[5]  = '{13, 1'b0, 1'b0, 3'd0, 5'h00, 8'hDF, 8'hC0, 1'b0};
    vt[6]  = '{0,  1'b0, 1'b1, 3'd5, 5'h07, 8'hDF, 8'hC0, 1'b0};
    vt[7]  = '{0,  1'b0, 1'b0, 3'd0, 5'h00, 8'hDF, 8'hF8, 1'b0};
    vt[8]  = '{24, 1'b0, 1'b0, 3'd0, 5'h00, 8'hFF, 8'hFF, 1'b1};
    vt[9]  = '{0,  1'b0, 1'b0, 3'd0, 5'h00, 8'hFE, 8'hC0, 1'b0};
    vt[10] = '{29, 1'b0, 1'b0, 3'd0, 5'h00, 8'hF7, 8'h08, 1'b0};
    vt[11] = '{0,  1'b1, 1'b1, 3'd3, 5'h1F, 8'hFF, 8'hFF, 1'b0};
    vt[12] = '{0,  1'b0, 1'b0, 3'd0, 5'h00, 8'hFF, 8'hFF, 1'b0};
    vt[13] = '{0,  1'b0, 1'b0, 3'd0, 5'h00, 8'hFE, 8'hC0, 1'b0};
    vt[14] = '{29, 1'b0, 1'b0, 3'd0, 5'h00, 8'hF7, 8'hC0, 1'b0};
    vt[15] = '{20, 1'b0, 1'b0, 3'd0, 5'h00, 8'hDF, 8'hC0, 1'b0};

    en_mask = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      repeat (vt[i].skip) tick();
      rst = vt[i].rst; wr_en = vt[i].we; wr_addr = vt[i].a; wr_data = vt[i].d;
      tick();
      rst = 1'b0; wr_en = 1'b0;
      check_all($sformatf("vec%0d", i), i, vt[i].edig, vt[i].eled, vt[i].etick);
    end

    run_scan(8'hFF, 8, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 170);
    run_scan(8'b0010_0100, 2, {18'd0, 3'd5, 3'd2}, 90);

    // Mask cleared mid-SHOW: blank immediately, hold, then resume after the BLANK slot.
    en_mask = 8'h01;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick();
    check_all("mask0_show", 2, 8'hFE, 8'hC0, 1'b0);
    tick(); tick();
    en_mask = 8'h00;
    tick();
    check_all("mask0_drop", 5, 8'hFF, 8'hFF, 1'b0);
    for (int t = 6; t <= 35; t++) begin
      tick();
      check("mask0_hold_dig", t, dig, 8'hFF);
      check("mask0_hold_tick", t, {7'd0, frame_tick}, 8'd0);
    end
    en_mask = 8'h01;
    tick();
    check_all("mask0_restore_blank", 36, 8'hFF, 8'hFF, 1'b1);
    tick();
    check_all("mask0_restore_show", 37, 8'hFE, 8'hC0, 1'b0);

`ifdef SEG_PWM_EN
    bright = 3'd3;
    en_mask = 8'h01;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int t = 2; t <= 9; t++) begin
      tick();
      check("pwm_dig", t, dig, 8'hFE);
      check("pwm_led", t, LED7S, (t - 2) <= 3 ? 8'hC0 : 8'hFF);
    end
    bright = 3'd7;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
